// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling, 3-sample majority vote and a
// registered-output receive FIFO with sticky overrun reporting.
module uart_rx_fifo #(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                   clkin,
    input  logic                   reset_n,
    input  logic                   uart_rxd,
    output logic [7:0]             m_tdata,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic                   frame_err,
    output logic                   overrun,
    input  logic                   clr_overrun,
    output logic [$clog2(DEPTH):0] fifo_count
);

    localparam int unsigned DIV   = CLK_HZ / (16 * BAUD);
    localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CW    = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t           r_state, w_state_nxt;
    logic             r_sync1, r_sync2, r_rxs_d;
    logic [1:0]       r_settle;
    logic [DIV_W-1:0] r_div_cnt;
    logic [3:0]       r_tick_idx;
    logic             r_s7, r_s8, r_bit;
    logic [2:0]       r_bit_cnt, w_bit_cnt_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_push, w_push_nxt, w_ferr_nxt;
    logic [7:0]       r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr, r_rd_ptr, w_rd_ptr_nxt;
    logic [CW-1:0]    w_count_nxt;
    logic             w_rxs, w_fall, w_restart, w_tick, w_vote, w_bit_end, w_bit;
    logic             w_pop, w_full, w_wr_ok, w_overflow, w_bypass;

    assign w_rxs     = r_sync2;
    assign w_fall    = r_rxs_d & ~w_rxs;
    assign w_restart = (r_state == S_IDLE) & w_fall;
    assign w_tick    = (r_div_cnt == DIV_W'(DIV - 1));
    assign w_vote    = w_tick & (r_tick_idx == 4'd9);
    assign w_bit_end = w_tick & (r_tick_idx == 4'd15);
    assign w_bit     = (r_s7 & r_s8) | (r_s7 & w_rxs) | (r_s8 & w_rxs);

    // Synchronizer plus a short settle count so post-reset flop values are never taken as line state
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_rxs_d  <= 1'b1;
            r_settle <= 2'd0;
        end else begin
            r_sync1  <= uart_rxd;
            r_sync2  <= r_sync1;
            r_rxs_d  <= r_sync2;
            if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;
        end
    end

    // Oversample timing and bit voting, realigned to every accepted start edge
    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt  <= '0;
            r_tick_idx <= '0;
            r_s7       <= 1'b1;
            r_s8       <= 1'b1;
            r_bit      <= 1'b1;
        end else begin
            if (w_restart) begin
                r_div_cnt  <= '0;
                r_tick_idx <= '0;
            end else if (w_tick) begin
                r_div_cnt  <= '0;
                r_tick_idx <= r_tick_idx + 4'd1;
            end else begin
                r_div_cnt  <= r_div_cnt + DIV_W'(1);
            end
            if (w_tick && r_tick_idx == 4'd7) r_s7 <= w_rxs;
            if (w_tick && r_tick_idx == 4'd8) r_s8 <= w_rxs;
            if (w_vote) r_bit <= w_bit;
        end
    end

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_WAIT_HIGH;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_push    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_shift   <= w_shift_nxt;
            r_push    <= w_push_nxt;
            frame_err <= w_ferr_nxt;
        end
    end

    // START/DATA act at the end of the bit; STOP acts on its vote so the next start edge is never missed
    always_comb begin
        w_state_nxt   = r_state;
        w_bit_cnt_nxt = r_bit_cnt;
        w_shift_nxt   = r_shift;
        w_push_nxt    = 1'b0;
        w_ferr_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_fall) w_state_nxt = S_START;
            end
            S_START: begin
                if (w_bit_end) begin
                    w_bit_cnt_nxt = '0;
                    w_state_nxt   = r_bit ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt   = {r_bit, r_shift[7:1]};
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_vote) begin
                    if (w_bit) begin
                        w_push_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_ferr_nxt  = 1'b1;
                        w_state_nxt = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (w_rxs && r_settle == 2'd3) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_WAIT_HIGH;
        endcase
    end

    assign w_pop      = m_tvalid & m_tready;
    assign w_full     = (fifo_count == CW'(DEPTH));
    assign w_wr_ok    = r_push & (~w_full | w_pop);
    assign w_overflow = r_push & w_full & ~w_pop;

    always_comb begin
        w_rd_ptr_nxt = r_rd_ptr;
        w_count_nxt  = fifo_count;
        if (w_pop) w_rd_ptr_nxt = r_rd_ptr + AW'(1);
        if (w_wr_ok && !w_pop) w_count_nxt = fifo_count + CW'(1);
        else if (!w_wr_ok && w_pop) w_count_nxt = fifo_count - CW'(1);
    end

    // A byte written into the slot that becomes the head must bypass the array read
    assign w_bypass = w_wr_ok & (r_wr_ptr == w_rd_ptr_nxt);

    always_ff @(posedge clkin) begin
        if (w_wr_ok) r_mem[r_wr_ptr] <= r_shift;
    end

    always_ff @(posedge clkin or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            fifo_count <= '0;
            m_tvalid   <= 1'b0;
            m_tdata    <= '0;
            overrun    <= 1'b0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            r_rd_ptr   <= w_rd_ptr_nxt;
            fifo_count <= w_count_nxt;
            m_tvalid   <= (w_count_nxt != '0);
            if (w_count_nxt != '0) m_tdata <= w_bypass ? r_shift : r_mem[w_rd_ptr_nxt];
            if (w_overflow) overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 Parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate.
REQ-003 Parameter DEPTH, default 16, receive FIFO entries; SHALL be a power of 2, range 2..256.
REQ-004 clkin  input  1  sole clock; all logic is rising-edge clocked by clkin.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 uart_rxd  input  1  asynchronous serial line, 8N1, idle high.
REQ-007 m_tdata  output  8  received byte at FIFO head.
REQ-008 m_tvalid  output  1  FIFO non-empty.
REQ-009 m_tready  input  1  consumer accept.
REQ-010 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-011 overrun  output  1  sticky flag, set when a byte is dropped on full FIFO.
REQ-012 clr_overrun  input  1  clears overrun.
REQ-013 fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-014 uart_rxd SHALL pass through a 2-flop synchronizer; all further logic uses the synchronized value (rxs).
REQ-015 Oversample tick SHALL pulse every DIV = floor(CLK_HZ/(16*BAUD)) cycles (54 at defaults); the tick counter restarts on start-edge detection.
REQ-016 Each bit value SHALL be the majority of rxs at ticks 7, 8 and 9 of that bit's 16-tick period.
REQ-017 FSM states: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-018 IDLE: a 1->0 transition on rxs -> START.
REQ-019 START: voted bit 0 -> DATA; voted bit 1 (glitch) -> IDLE, no output.
REQ-020 DATA: 8 bits, LSB first, shifted into the byte register; after bit 7 -> STOP.
REQ-021 STOP: voted 1 -> push byte, then IDLE; voted 0 -> pulse frame_err, discard byte, then WAIT_HIGH.
REQ-022 WAIT_HIGH: remain until rxs = 1, then IDLE; break conditions SHALL yield one frame_err only.
REQ-023 Push SHALL occur on the cycle after the stop vote; m_tvalid SHALL assert on the cycle after the push (no fall-through).
REQ-024 Pop SHALL occur on a cycle with m_tvalid & m_tready; m_tdata SHALL then present the next entry on the following cycle.
REQ-025 Push while fifo_count = DEPTH and no pop in the same cycle: byte dropped, overrun set, FIFO unchanged.
REQ-026 Push while full with a simultaneous pop: push accepted, fifo_count unchanged, no overrun.
REQ-027 Push and pop in the same cycle at any non-full occupancy: fifo_count unchanged.
REQ-028 Overrun set and clr_overrun in the same cycle: set wins.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH; fifo_count SHALL never exceed DEPTH.
REQ-030 m_tdata and m_tvalid SHALL be stable while m_tvalid=1 and m_tready=0.

Reset
REQ-031 reset_n low SHALL asynchronously force: FSM to WAIT_HIGH; FIFO empty; m_tvalid=0; m_tdata=0; fifo_count=0; frame_err=0; overrun=0; synchronizer flops=1.
REQ-032 After reset release, the FSM SHALL wait for rxs=1 before accepting a start edge, so a reset mid-frame never yields a partial byte.

Verification
REQ-033 Send 0xA5, 8N1, at BAUD; m_tready=1 -> m_tdata=0xA5 with m_tvalid for exactly 1 cycle; frame_err=0.
REQ-034 Low pulse of 4 DIV on an idle line -> no push, no frame_err, FSM back in IDLE.
REQ-035 Send 0x3C with stop bit held 0, then line low for 20 bit times -> exactly one frame_err pulse; no push; next valid 0x55 received correctly.
REQ-036 m_tready=0; send DEPTH+1 bytes 0x00..0x10 -> fifo_count=DEPTH, overrun=1; drain yields 0x00..0x0F in order; clr_overrun -> overrun=0.
REQ-037 FIFO full; push coincides with pop -> no overrun; count stays DEPTH; the new byte appears last when drained.
REQ-038 Assert reset_n low during bit 4 of a frame, release mid-frame -> no push from that frame; next full frame 0x81 received correctly.
